// File: rtl/pipe_stage_chain_pkg.sv
// Shared field indices and default widths for the EXE/MEM/WB pipeline register chain.
package pipe_pkg;
  localparam int CTRL_WB = 2;
  localparam int CTRL_MR = 1;
  localparam int CTRL_MW = 0;

  localparam int PC_W   = 32;
  localparam int REG_W  = 32;
  localparam int DEST_W = 4;

  localparam int CTRL_DEF_W = 3;
  // Default payload: {PC, ALU_Res, Val_Rm, Dest}
  localparam int DATA_DEF_W = PC_W + REG_W + REG_W + DEST_W;

  typedef logic [CTRL_DEF_W-1:0] ctrl_t;
endpackage

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline stage: valid/ctrl/data register with advance and flush.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_DEF_W,
  parameter int DATA_W = DATA_DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              adv,
  input  logic              up_valid,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              v_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  // Data is only written on a real transfer; a bubble zeroes ctrl so it can never fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
    end else if (adv) begin
      v_q <= up_valid;
      if (up_valid) begin
        ctrl_q <= up_ctrl;
        data_q <= up_data;
      end else begin
        ctrl_q <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage pipeline register chain with stall, flush and occupancy count.
// Optional 1-entry input skid register: define PIPE_STAGE_SKID_EN.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_DEF_W,
  parameter int DATA_W = DATA_DEF_W,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]             v;
  logic [DEPTH-1:0]             rdy;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             up_v;
  logic [DEPTH-1:0][CTRL_W-1:0] up_c;
  logic [DEPTH-1:0][DATA_W-1:0] up_d;

  logic              acc, out_xfer;
  logic              src_v;
  logic [CTRL_W-1:0] src_c;
  logic [DATA_W-1:0] src_d;

  assign acc      = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Flattened ready chain: stage i can take an entry if any stage at or after it has a hole.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = 0; j < DEPTH; j++)
        if (j >= i && !v[j]) rdy[i] = 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // in_ready comes straight from the skid flop, breaking the out_ready path.
  assign in_ready = !skid_v & !flush;
  assign src_v    = skid_v | acc;
  assign src_c    = skid_v ? skid_ctrl : in_ctrl;
  assign src_d    = skid_v ? skid_data : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
    end else if (skid_v) begin
      if (rdy[0]) skid_v <= 1'b0;
    end else if (acc && !rdy[0]) begin
      skid_v    <= 1'b1;
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end
`else
  assign in_ready = rdy[0] & !flush;
  assign src_v    = acc;
  assign src_c    = in_ctrl;
  assign src_d    = in_data;
`endif

  always_comb begin
    up_v    = '0;
    up_c    = '0;
    up_d    = '0;
    up_v[0] = src_v;
    up_c[0] = src_c;
    up_d[0] = src_d;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_c[i] = ctrl_q[i-1];
      up_d[i] = data_q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .adv      (rdy[i]),
      .up_valid (up_v[i]),
      .up_ctrl  (up_c[i]),
      .up_data  (up_d[i]),
      .v_q      (v[i]),
      .ctrl_q   (ctrl_q[i]),
      .data_q   (data_q[i])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = v[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
  assign out_data  = data_q[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (flush)             count <= '0;
    else if (acc && !out_xfer)  count <= count + CNT_W'(1);
    else if (!acc && out_xfer)  count <= count - CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: DEPTH=1,2,3 chains share stimulus and are checked against a positional model.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int CW = 3;
  localparam int DW = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  always #5 clk = ~clk;

  logic ir1, ov1, ir2, ov2, ir3, ov3;
  logic [CW-1:0] oc1, oc2, oc3;
  logic [DW-1:0] od1, od2, od3;
  logic [1:0] cnt1, cnt2;
  logic [2:0] cnt3;

  logic          ir[3], ov[3];
  logic [CW-1:0] oc[3];
  logic [DW-1:0] od[3];
  int            cnt[3];

  always_comb begin
    ir[0] = ir1; ov[0] = ov1; oc[0] = oc1; od[0] = od1; cnt[0] = int'(cnt1);
    ir[1] = ir2; ov[1] = ov2; oc[1] = oc2; od[1] = od2; cnt[1] = int'(cnt2);
    ir[2] = ir3; ov[2] = ov3; oc[2] = oc3; od[2] = od3; cnt[2] = int'(cnt3);
  end

  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .count(cnt1));
  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
    .out_ctrl(oc2), .out_data(od2), .count(cnt2));
  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready),
    .out_ctrl(oc3), .out_data(od3), .count(cnt3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Model: per instance, an ordered list of entries with their stage position
  // (-1 = skid, DEPTH-1 = output stage). Oldest entry is index 0.
  int            mp[3][6];
  logic [CW-1:0] mc[3][6];
  logic [DW-1:0] md[3][6];
  int            mn[3];

  task automatic model_cycle(input int m, input logic iv, input logic [CW-1:0] ic,
                             input logic [DW-1:0] id, input logic fl, input logic ordy,
                             output logic exp_ir);
    int   d;
    int   n;
    int   np[6];
    logic free0;
`ifdef PIPE_STAGE_SKID_EN
    logic skid_occ;
`endif
    d = m + 1;
    n = mn[m];
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        if (mp[m][0] == d - 1) np[0] = ordy ? d : mp[m][0];
        else                   np[0] = mp[m][0] + 1;
      end else begin
        np[k] = (np[k-1] != mp[m][k] + 1) ? mp[m][k] + 1 : mp[m][k];
      end
    end
    free0 = (n == 0) || (np[n-1] != 0);
`ifdef PIPE_STAGE_SKID_EN
    skid_occ = (n > 0) && (mp[m][n-1] == -1);
    exp_ir = !skid_occ && !fl;
`else
    exp_ir = free0 && !fl;
`endif
    if (fl) begin
      mn[m] = 0;
      return;
    end
    for (int k = 0; k < n; k++) mp[m][k] = np[k];
    if (iv && exp_ir) begin
      mp[m][n] = free0 ? 0 : -1;
      mc[m][n] = ic;
      md[m][n] = id;
      n++;
    end
    if (n > 0 && mp[m][0] == d) begin
      for (int k = 1; k < n; k++) begin
        mp[m][k-1] = mp[m][k];
        mc[m][k-1] = mc[m][k];
        md[m][k-1] = md[m][k];
      end
      n--;
    end
    mn[m] = n;
  endtask

  // Drive one cycle's inputs at the falling edge, compare just after, then advance the model.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic fl, input logic ordy);
    logic ev, eir;
    @(negedge clk);
    in_valid = iv; in_ctrl = ic; in_data = id; flush = fl; out_ready = ordy;
    #1;
    for (int m = 0; m < 3; m++) begin
      ev = (mn[m] > 0) && (mp[m][0] == m);
      chk($sformatf("d%0d_out_valid", m + 1), 128'(ov[m]), 128'(ev));
      chk($sformatf("d%0d_out_ctrl", m + 1), 128'(oc[m]), ev ? 128'(mc[m][0]) : 128'(0));
      if (ev) chk($sformatf("d%0d_out_data", m + 1), 128'(od[m]), 128'(md[m][0]));
      chk($sformatf("d%0d_count", m + 1), 128'(cnt[m]), 128'(mn[m]));
      model_cycle(m, iv, ic, id, fl, ordy, eir);
      chk($sformatf("d%0d_in_ready", m + 1), 128'(ir[m]), 128'(eir));
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input logic wb, input logic mr, input logic mw);
    logic [CW-1:0] c;
    c = '0;
    c[CTRL_WB] = wb;
    c[CTRL_MR] = mr;
    c[CTRL_MW] = mw;
    return c;
  endfunction

  initial begin
    logic [DW-1:0] rd;
    for (int m = 0; m < 3; m++) mn[m] = 0;

    // Reset state
    @(negedge clk); #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_d%0d_out_valid", m + 1), 128'(ov[m]), 128'(0));
      chk($sformatf("rst_d%0d_out_ctrl", m + 1), 128'(oc[m]), 128'(0));
      chk($sformatf("rst_d%0d_out_data", m + 1), 128'(od[m]), 128'(0));
      chk($sformatf("rst_d%0d_count", m + 1), 128'(cnt[m]), 128'(0));
    end
    @(negedge clk); rst = 1'b0;

    // Streaming 0x10..0x14 back-to-back
    for (int i = 0; i < 5; i++) step(1'b1, mk_ctrl(1, 0, 1), DW'(16 + i), 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Fill then stall for 5 cycles while still offering, then drain
    for (int i = 0; i < 3; i++) step(1'b1, mk_ctrl(1, 0, 0), DW'(32 + i), 1'b0, 1'b0);
    repeat (5) step(1'b1, mk_ctrl(1, 0, 0), DW'(48), 1'b0, 1'b0);
    repeat (6) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush with two in flight and a new entry offered on the flush cycle
    step(1'b1, mk_ctrl(1, 1, 0), DW'(64), 1'b0, 1'b1);
    step(1'b1, mk_ctrl(1, 1, 0), DW'(65), 1'b0, 1'b1);
    step(1'b1, mk_ctrl(1, 1, 0), DW'(66), 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Bubble between two entries
    step(1'b1, mk_ctrl(0, 1, 1), DW'(80), 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, mk_ctrl(0, 1, 1), DW'(81), 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

`ifdef PIPE_STAGE_SKID_EN
    // Skid absorbs one extra entry on a stalled DEPTH=1 chain
    step(1'b1, mk_ctrl(1, 0, 0), DW'(10), 1'b0, 1'b0);
    step(1'b1, mk_ctrl(1, 0, 0), DW'(11), 1'b0, 1'b0);
    step(1'b1, mk_ctrl(1, 0, 0), DW'(12), 1'b0, 1'b0);
    chk("skid_d1_count", 128'(cnt[0]), 128'(2));
    chk("skid_d1_in_ready", 128'(ir[0]), 128'(0));
    repeat (5) step(1'b0, '0, '0, 1'b0, 1'b1);
`endif

    // Asynchronous reset with entries in flight
    step(1'b1, mk_ctrl(0, 1, 0), DW'(96), 1'b0, 1'b0);
    step(1'b1, mk_ctrl(0, 1, 0), DW'(97), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("arst_d%0d_out_valid", m + 1), 128'(ov[m]), 128'(0));
      chk($sformatf("arst_d%0d_out_ctrl", m + 1), 128'(oc[m]), 128'(0));
      chk($sformatf("arst_d%0d_count", m + 1), 128'(cnt[m]), 128'(0));
      mn[m] = 0;
    end
    @(negedge clk); rst = 1'b0;

    // Randomized traffic with occasional flushes
    repeat (400) begin
      rd = DW'({$urandom, $urandom, $urandom, $urandom});
      step(1'($urandom_range(0, 1)), CW'($urandom_range(0, 7)), rd,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    repeat (8) step(1'b0, '0, '0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
